// File: rtl/polinomio_horner.sv
// polinomio_horner: evaluates P(X) = sum c_i*X^i with Horner's method.
// One multiply-accumulate step per clock. The degree is chosen at run time
// and clamped to DEGREE. The result is truncated to WIDTH bits. The overflow
// flag is sticky and covers the current or most recent evaluation.
// Optional feature macro: POLI_SIGNED_EN. When it is defined, X, the
// coefficients and the accumulator are two's complement values.
module polinomio_horner #(
   parameter int WIDTH  = 16,
   parameter int DEGREE = 4,
   parameter int GRAU_W = 3
) (
   input  logic                        ck,
   input  logic                        rst,
   input  logic                        inicio,
   input  logic [GRAU_W-1:0]           grau,
   input  logic [WIDTH-1:0]            X,
   input  logic [(DEGREE+1)*WIDTH-1:0] coef,
   output logic                        ocupado,
   output logic                        pronto,
   output logic                        overflow,
   output logic [WIDTH-1:0]            resultado
);

   localparam int FW    = 2*WIDTH + 1;
   localparam int NSLOT = 2**GRAU_W;
   localparam logic [GRAU_W-1:0] G_MAX = GRAU_W'(DEGREE);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t                        r_state;
   state_t                        w_state_next;
   logic [WIDTH-1:0]              r_x;
   logic [(DEGREE+1)*WIDTH-1:0]   r_coef;
   logic [WIDTH-1:0]              r_acc;
   logic [GRAU_W-1:0]             r_cnt;
   logic                          r_pend;     // final acc is waiting to be published
   logic                          r_pronto;
   logic                          r_overflow;
   logic [WIDTH-1:0]              r_resultado;

   logic                          w_start;
   logic [GRAU_W-1:0]             w_g;
   logic [GRAU_W-1:0]             w_cnt_m1;
   logic [WIDTH-1:0]              w_in_c  [NSLOT];
   logic [WIDTH-1:0]              w_reg_c [NSLOT];
   logic [WIDTH-1:0]              w_c_cur;
   logic [FW-1:0]                 w_full;
   logic                          w_ovf;

   // Coefficient views indexed by degree. Slots above DEGREE read as zero, so
   // any GRAU_W-bit index is safe.
   generate
      for (genvar gi = 0; gi < NSLOT; gi++) begin : g_coef
         if (gi <= DEGREE) begin : g_used
            assign w_in_c[gi]  = coef[gi*WIDTH +: WIDTH];
            assign w_reg_c[gi] = r_coef[gi*WIDTH +: WIDTH];
         end else begin : g_unused
            assign w_in_c[gi]  = '0;
            assign w_reg_c[gi] = '0;
         end
      end
   endgenerate

   assign w_g      = (grau > G_MAX) ? G_MAX : grau;
   assign w_cnt_m1 = r_cnt - GRAU_W'(1);
   assign w_c_cur  = w_reg_c[w_cnt_m1];
   assign w_start  = inicio && (r_state != CALC);

`ifdef POLI_SIGNED_EN
   // Signed multiply-add. Overflow is flagged when the result does not fit in
   // the signed WIDTH-bit range, i.e. the top bits are not all copies of the sign.
   assign w_full = FW'(signed'(r_acc)) * FW'(signed'(r_x)) + FW'(signed'(w_c_cur));
   assign w_ovf  = !((&w_full[FW-1:WIDTH-1]) || !(|w_full[FW-1:WIDTH-1]));
`else
   // Unsigned multiply-add. Any bit at or above 2^WIDTH means overflow.
   assign w_full = FW'(r_acc) * FW'(r_x) + FW'(w_c_cur);
   assign w_ovf  = |w_full[FW-1:WIDTH];
`endif

   // State register
   always_ff @(posedge ck) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_next;
   end

   // Next-state logic. A start from IDLE or DONE behaves the same way.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE, DONE: begin
            if (inicio) w_state_next = (w_g == '0) ? DONE : CALC;
         end
         CALC: begin
            if (r_cnt == GRAU_W'(1)) w_state_next = DONE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   // Datapath: latch on start, one Horner step per CALC cycle, and publish
   // the result on the first cycle spent in DONE.
   always_ff @(posedge ck) begin
      if (rst) begin
         r_x         <= '0;
         r_coef      <= '0;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_pend      <= 1'b0;
         r_pronto    <= 1'b0;
         r_overflow  <= 1'b0;
         r_resultado <= '0;
      end else if (w_start) begin
         r_x        <= X;
         r_coef     <= coef;
         r_acc      <= w_in_c[w_g];
         r_cnt      <= w_g;
         r_pend     <= (w_g == '0);
         r_pronto   <= 1'b0;
         r_overflow <= 1'b0;
      end else if (r_state == CALC) begin
         r_acc <= w_full[WIDTH-1:0];
         r_cnt <= w_cnt_m1;
         if (w_ovf)              r_overflow <= 1'b1;
         if (r_cnt == GRAU_W'(1)) r_pend    <= 1'b1;
      end else if (r_state == DONE && r_pend) begin
         r_resultado <= r_acc;
         r_pronto    <= 1'b1;
         r_pend      <= 1'b0;
      end
   end

   assign ocupado   = (r_state == CALC);
   assign pronto    = r_pronto;
   assign overflow  = r_overflow;
   assign resultado = r_resultado;

endmodule

// File: tb/tb_polinomio_horner.sv
// Directed self-checking bench for polinomio_horner (WIDTH=16, DEGREE=4).
// A vector table drives complete evaluations. Hand-written sequences cover
// reset in the middle of CALC, inicio pulsed again during CALC, and rst
// arriving together with inicio.
module tb_polinomio_horner;

   logic        ck = 1'b0;
   logic        rst;
   logic        inicio;
   logic [2:0]  grau;
   logic [15:0] X;
   logic [79:0] coef;
   logic        ocupado;
   logic        pronto;
   logic        overflow;
   logic [15:0] resultado;

   int n_cmp = 0;
   int n_bad = 0;

   polinomio_horner #(.WIDTH(16), .DEGREE(4), .GRAU_W(3)) dut (
      .ck        (ck),
      .rst       (rst),
      .inicio    (inicio),
      .grau      (grau),
      .X         (X),
      .coef      (coef),
      .ocupado   (ocupado),
      .pronto    (pronto),
      .overflow  (overflow),
      .resultado (resultado)
   );

   always #5 ck = ~ck;

   typedef struct packed {
      logic [2:0]  g;
      logic [15:0] x;
      logic [79:0] coef;   // {c4, c3, c2, c1, c0}
      logic [15:0] res;
      logic        ovf;
   } vec_t;

   vec_t vecs [6];
   vec_t v_ovf, v_rep;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Runs one evaluation. It checks the start edge, latency, busy cycles,
   // result, overflow and the hold phase. With repulse set, inicio is pulsed
   // again while CALC is running.
   task automatic run_eval(input vec_t v, input int idx, input bit repulse);
      int lat, busy, ge;
      ge = (v.g > 3'd4) ? 4 : int'(v.g);
      grau = v.g; X = v.x; coef = v.coef; inicio = 1'b1;
      @(posedge ck); #1;
      inicio = 1'b0; grau = ~v.g; X = ~v.x; coef = ~v.coef;
      check($sformatf("v%0d_pronto_drop", idx), {31'd0, pronto}, 32'd0);
      check($sformatf("v%0d_ovf_clear", idx), {31'd0, overflow}, 32'd0);
      check($sformatf("v%0d_busy_start", idx), {31'd0, ocupado}, (ge != 0) ? 32'd1 : 32'd0);
      lat = 0; busy = 0;
      while (pronto !== 1'b1 && lat < 40) begin
         if (ocupado === 1'b1) busy++;
         inicio = (repulse && lat == 1) ? 1'b1 : 1'b0;
         @(posedge ck); #1;
         lat++;
      end
      inicio = 1'b0;
      check($sformatf("v%0d_latency", idx), lat, ge + 1);
      check($sformatf("v%0d_busy_cycles", idx), busy, ge);
      check($sformatf("v%0d_resultado", idx), {16'd0, resultado}, {16'd0, v.res});
      check($sformatf("v%0d_overflow", idx), {31'd0, overflow}, {31'd0, v.ovf});
      @(posedge ck); #1;
      check($sformatf("v%0d_hold_pronto", idx), {31'd0, pronto}, 32'd1);
      check($sformatf("v%0d_hold_res", idx), {16'd0, resultado}, {16'd0, v.res});
      $display("vec %0d: grau=%0d X=%h -> resultado=%h overflow=%0b latency=%0d busy=%0d",
               idx, v.g, v.x, resultado, overflow, lat, busy);
   endtask

   initial begin
      v_ovf = '{g: 3'd2, x: 16'd300, coef: {16'd0, 16'd0, 16'd1000, 16'd0, 16'd0},
                res: 16'd19072, ovf: 1'b1};
      v_rep = '{g: 3'd4, x: 16'd2, coef: {16'd1, 16'd2, 16'd3, 16'd4, 16'd5},
                res: 16'd57, ovf: 1'b0};
`ifdef POLI_SIGNED_EN
      vecs[0] = '{g: 3'd1, x: 16'hFFFD, coef: {16'd0, 16'd0, 16'd0, 16'd5, 16'd2},
                  res: 16'hFFF3, ovf: 1'b0};
      vecs[1] = '{g: 3'd1, x: 16'h7FFF, coef: {16'd0, 16'd0, 16'd0, 16'd2, 16'd0},
                  res: 16'hFFFE, ovf: 1'b1};
      vecs[2] = '{g: 3'd1, x: 16'hFFFF, coef: {16'd0, 16'd0, 16'd0, 16'h8000, 16'd0},
                  res: 16'h8000, ovf: 1'b1};
      vecs[3] = '{g: 3'd2, x: 16'd2, coef: {16'd0, 16'd0, 16'hFFFF, 16'hFFFE, 16'd1},
                  res: 16'hFFF9, ovf: 1'b0};
      vecs[4] = v_ovf;
      vecs[5] = '{g: 3'd0, x: 16'd9, coef: {16'd1, 16'd1, 16'd1, 16'd1, 16'd777},
                  res: 16'd777, ovf: 1'b0};
`else
      vecs[0] = '{g: 3'd2, x: 16'd23, coef: {16'd0, 16'd0, 16'd38, 16'd333, 16'd4902},
                  res: 16'd32663, ovf: 1'b0};
      vecs[1] = v_ovf;
      vecs[2] = '{g: 3'd1, x: 16'hFFFF, coef: {16'd0, 16'd0, 16'd0, 16'hFFFF, 16'hFFFF},
                  res: 16'd0, ovf: 1'b1};
      vecs[3] = v_rep;
      vecs[4] = '{g: 3'd7, x: 16'd2, coef: {16'd1, 16'd2, 16'd3, 16'd4, 16'd5},
                  res: 16'd57, ovf: 1'b0};
      vecs[5] = '{g: 3'd0, x: 16'd9, coef: {16'd1, 16'd1, 16'd1, 16'd1, 16'd777},
                  res: 16'd777, ovf: 1'b0};
`endif

      rst = 1'b1; inicio = 1'b0; grau = '0; X = '0; coef = '0;
      repeat (2) @(posedge ck);
      #1;
      check("reset_pronto", {31'd0, pronto}, 32'd0);
      check("reset_overflow", {31'd0, overflow}, 32'd0);
      check("reset_ocupado", {31'd0, ocupado}, 32'd0);
      check("reset_resultado", {16'd0, resultado}, 32'd0);
      rst = 1'b0;
      @(posedge ck); #1;

      // Table vectors run back to back. Every start after the first comes from DONE.
      for (int i = 0; i < 6; i++) run_eval(vecs[i], i, 1'b0);

      // Reset in the middle of CALC, after the first step has already overflowed.
      grau = v_ovf.g; X = v_ovf.x; coef = v_ovf.coef; inicio = 1'b1;
      @(posedge ck); #1;
      inicio = 1'b0;
      @(posedge ck); #1;
      check("midcalc_busy", {31'd0, ocupado}, 32'd1);
      check("midcalc_ovf", {31'd0, overflow}, 32'd1);
      rst = 1'b1;
      @(posedge ck); #1;
      rst = 1'b0;
      check("abort_pronto", {31'd0, pronto}, 32'd0);
      check("abort_overflow", {31'd0, overflow}, 32'd0);
      check("abort_resultado", {16'd0, resultado}, 32'd0);
      check("abort_ocupado", {31'd0, ocupado}, 32'd0);
      repeat (5) @(posedge ck);
      #1;
      check("abort_no_pronto", {31'd0, pronto}, 32'd0);
      $display("seq abort: pronto=%0b resultado=%h", pronto, resultado);

      // Normal evaluation after the abort. inicio is pulsed again during CALC and must be ignored.
      run_eval(v_rep, 10, 1'b1);

      // rst and inicio on the same edge: the start must not be accepted.
      grau = 3'd0; X = 16'd1; coef = {64'd0, 16'd777};
      rst = 1'b1; inicio = 1'b1;
      @(posedge ck); #1;
      rst = 1'b0; inicio = 1'b0;
      repeat (3) @(posedge ck);
      #1;
      check("rst_win_pronto", {31'd0, pronto}, 32'd0);
      check("rst_win_res", {16'd0, resultado}, 32'd0);
      $display("seq rst+inicio: pronto=%0b resultado=%h", pronto, resultado);

      // Normal operation resumes.
      run_eval(vecs[5], 11, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
